// File: rtl/qupls4_preg_freelist.sv
// Physical-register free-list allocator for the Qupls4 rename stage.
//
// A circular buffer of CAP preg numbers. Pregs NAREG..NPREG-1 start out
// free. One allocation per cycle leaves at head, and up to two retired pregs
// per cycle enter at tail. A single checkpoint of head allows speculative
// allocations to be rolled back on a mispredict.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   alloc_req, alloc_Rdz       decoded instruction present / has no destination
//   alloc_rdy, alloc_preg      zero-cycle grant and granted preg (0 if no dest)
//   free_v, free_preg0/1       two free slots, slot 0 enqueued first
//   ckpt_save, ckpt_restore    capture / roll back the allocation pointer
//   free_cnt, empty            registered occupancy of the free list
//   ovf                        sticky: a free was dropped because the list was full
//   stall_cnt                  stalled-allocation counter
//
// Build option: define QUPLS4_FREELIST_STATS_EN to enable the stall counter;
// otherwise stall_cnt is tied to 0.

module qupls4_preg_freelist #(
  parameter int unsigned NPREG = 512,
  parameter int unsigned NAREG = 128,
  parameter int unsigned PREGW = $clog2(NPREG),
  parameter int unsigned CAP   = NPREG - NAREG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  input  logic             alloc_Rdz,
  output logic             alloc_rdy,
  output logic [PREGW-1:0] alloc_preg,
  input  logic [1:0]       free_v,
  input  logic [PREGW-1:0] free_preg0,
  input  logic [PREGW-1:0] free_preg1,
  input  logic             ckpt_save,
  input  logic             ckpt_restore,
  output logic [PREGW:0]   free_cnt,
  output logic             empty,
  output logic             ovf,
  output logic [31:0]      stall_cnt
);

  // Pointers carry one wrap bit; they count modulo 2*CAP, which need not be
  // a power of two, so wrap is explicit.
  localparam int unsigned PTRW = PREGW + 1;
  localparam logic [PTRW-1:0] CapP  = PTRW'(CAP);
  localparam logic [PTRW-1:0] LastP = PTRW'(2 * CAP - 1);

  logic [PREGW-1:0] entry_q [CAP];
  logic [PTRW-1:0]  head_q, head_d, tail_q, tail_d, ckpt_q, ckpt_d;
  logic             ovf_q, ovf_d;

  logic             grant, v0, v1, adm0, adm1;
  logic [PTRW-1:0]  base, cnt1, wr1_ptr;
  logic [PREGW-1:0] wr0_idx, wr1_idx;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == LastP) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PREGW-1:0] ptr_idx(input logic [PTRW-1:0] p);
    logic [PTRW-1:0] r;
    r = (p >= CapP) ? p - CapP : p;
    return r[PREGW-1:0];
  endfunction

  // Distance tail - head modulo 2*CAP; the 10-bit wrap of t + 2*CAP is
  // harmless because the true result is always below 2*CAP.
  function automatic logic [PTRW-1:0] ptr_diff(input logic [PTRW-1:0] t,
                                               input logic [PTRW-1:0] h);
    return (t >= h) ? t - h : t + (LastP + 1'b1) - h;
  endfunction

  // Count derives only from registered pointers, so frees never bypass.
  assign free_cnt = ptr_diff(tail_q, head_q);
  assign empty    = (free_cnt == '0);
  assign ovf      = ovf_q;

  assign alloc_rdy  = alloc_req & (alloc_Rdz | ~empty) & ~ckpt_restore;
  assign alloc_preg = alloc_Rdz ? '0 : entry_q[ptr_idx(head_q)];

  always_comb begin
    grant  = alloc_rdy & ~alloc_Rdz;
    head_d = ckpt_restore ? ckpt_q : (grant ? ptr_inc(head_q) : head_q);
    ckpt_d = (ckpt_save & ~ckpt_restore) ? head_d : ckpt_q;

    // Overflow is judged against the post-edge head so a restore that
    // reclaims entries is accounted for.
    base    = ptr_diff(tail_q, head_d);
    v0      = free_v[0] & (free_preg0 != '0);
    v1      = free_v[1] & (free_preg1 != '0);
    adm0    = v0 & (base < CapP);
    cnt1    = base + PTRW'(adm0);
    adm1    = v1 & (cnt1 < CapP);
    ovf_d   = ovf_q | (v0 & ~adm0) | (v1 & ~adm1);

    // Slot 1 packs into tail when slot 0 did not enqueue.
    wr1_ptr = adm0 ? ptr_inc(tail_q) : tail_q;
    wr0_idx = ptr_idx(tail_q);
    wr1_idx = ptr_idx(wr1_ptr);
    tail_d  = adm1 ? ptr_inc(wr1_ptr) : wr1_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CAP; i++) begin
        entry_q[i] <= PREGW'(NAREG + i);
      end
      head_q <= '0;
      tail_q <= CapP;
      ckpt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (adm0) entry_q[wr0_idx] <= free_preg0;
      if (adm1) entry_q[wr1_idx] <= free_preg1;
      head_q <= head_d;
      tail_q <= tail_d;
      ckpt_q <= ckpt_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef QUPLS4_FREELIST_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (alloc_req & ~alloc_Rdz & ~alloc_rdy & ~(&stall_q)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_qupls4_preg_freelist.sv
// Self-checking bench for qupls4_preg_freelist: a vector table, directed
// multi-cycle sequences, and randomized traffic against an integer model.

module tb_qupls4_preg_freelist;
  localparam int NPREG = 512;
  localparam int NAREG = 128;
  localparam int PREGW = 9;
  localparam int CAP   = NPREG - NAREG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_req, alloc_Rdz, alloc_rdy;
  logic [PREGW-1:0] alloc_preg;
  logic [1:0]       free_v;
  logic [PREGW-1:0] free_preg0, free_preg1;
  logic             ckpt_save, ckpt_restore;
  logic [PREGW:0]   free_cnt;
  logic             empty, ovf;
  logic [31:0]      stall_cnt;

  qupls4_preg_freelist #(
    .NPREG (NPREG),
    .NAREG (NAREG),
    .PREGW (PREGW),
    .CAP   (CAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_Rdz    (alloc_Rdz),
    .alloc_rdy    (alloc_rdy),
    .alloc_preg   (alloc_preg),
    .free_v       (free_v),
    .free_preg0   (free_preg0),
    .free_preg1   (free_preg1),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .free_cnt     (free_cnt),
    .empty        (empty),
    .ovf          (ovf),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: unbounded integer pointers over a modular array.
  int     m_head, m_tail, m_ckpt;
  int     m_mem [CAP];
  bit     m_ovf;
  longint m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CAP; i++) m_mem[i] = NAREG + i;
    m_head  = 0;
    m_tail  = CAP;
    m_ckpt  = 0;
    m_ovf   = 0;
    m_stall = 0;
  endtask

  // One clock: drive at edge+1, sample combinational outputs at edge+5,
  // advance the model, then check registered outputs at next edge+1.
  task automatic cycle(input bit req, input bit rdz, input bit [1:0] fv, input int p0,
                       input int p1, input bit save, input bit rest, input bit rst,
                       output bit g_rdy, output int g_preg);
    bit e_rdy;
    int e_preg, nh, base;
    rst_n        = ~rst;
    alloc_req    = req;
    alloc_Rdz    = rdz;
    free_v       = fv;
    free_preg0   = PREGW'(p0);
    free_preg1   = PREGW'(p1);
    ckpt_save    = save;
    ckpt_restore = rest;
    e_rdy  = req && (rdz || (m_tail - m_head) > 0) && !rest;
    e_preg = rdz ? 0 : m_mem[m_head % CAP];
    #4;
    g_rdy  = alloc_rdy;
    g_preg = int'(alloc_preg);
    if (!rst) begin
      chk("model_alloc_rdy", alloc_rdy, e_rdy);
      if (e_rdy) chk("model_alloc_preg", alloc_preg, e_preg);
    end
    if (rst) begin
      model_reset();
    end else begin
      nh = rest ? m_ckpt : ((e_rdy && !rdz) ? m_head + 1 : m_head);
      if (!rest && save) m_ckpt = nh;
      m_head = nh;
      base = m_tail - m_head;
      if (fv[0] && p0 != 0) begin
        if (base < CAP) begin m_mem[m_tail % CAP] = p0; m_tail++; base++; end
        else m_ovf = 1;
      end
      if (fv[1] && p1 != 0) begin
        if (base < CAP) begin m_mem[m_tail % CAP] = p1; m_tail++; end
        else m_ovf = 1;
      end
`ifdef QUPLS4_FREELIST_STATS_EN
      if (req && !rdz && !e_rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
`endif
    end
    @(posedge clk);
    #1;
    chk("model_free_cnt", free_cnt, m_tail - m_head);
    chk("model_empty", empty, (m_tail - m_head) == 0);
    chk("model_ovf", ovf, m_ovf);
    chk("model_stall_cnt", stall_cnt, m_stall);
  endtask

  typedef struct {
    bit       req;
    bit       rdz;
    bit [1:0] fv;
    int       p0;
    int       p1;
    bit       save;
    bit       rest;
    bit       e_rdy;
    int       e_preg;
    bit       chkp;
    int       e_cnt;
    bit       e_ovf;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bit g_rdy;
    int g_preg, first_post_save, cnt_after_save;
    bit req, rdz, save, rest, rst;
    bit [1:0] fv;
    int p0, p1;

    // req rdz fv p0 p1 save rest | rdy preg chkp cnt ovf
    tbl[0] = '{1, 0, 2'b00, 0,  0,  0, 0, 1, 128, 1, 383, 0};
    tbl[1] = '{1, 0, 2'b00, 0,  0,  0, 0, 1, 129, 1, 382, 0};
    tbl[2] = '{1, 0, 2'b00, 0,  0,  0, 0, 1, 130, 1, 381, 0};
    tbl[3] = '{1, 1, 2'b00, 0,  0,  0, 0, 1, 0,   1, 381, 0};
    tbl[4] = '{0, 0, 2'b01, 0,  0,  0, 0, 0, 0,   0, 381, 0};
    tbl[5] = '{0, 0, 2'b11, 7,  9,  0, 0, 0, 0,   0, 383, 0};
    tbl[6] = '{0, 0, 2'b11, 11, 12, 0, 0, 0, 0,   0, 384, 1};
    tbl[7] = '{1, 0, 2'b00, 0,  0,  0, 0, 1, 131, 1, 383, 1};
    tbl[8] = '{1, 0, 2'b01, 5,  0,  0, 0, 1, 132, 1, 383, 1};

    rst_n = 1'b0; alloc_req = 0; alloc_Rdz = 0; free_v = 0;
    free_preg0 = 0; free_preg1 = 0; ckpt_save = 0; ckpt_restore = 0;
    @(posedge clk);
    #1;

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g_rdy, g_preg);
    chk("reset_free_cnt", free_cnt, 384);
    chk("reset_empty", empty, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_stall", stall_cnt, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].req, tbl[i].rdz, tbl[i].fv, tbl[i].p0, tbl[i].p1, tbl[i].save,
            tbl[i].rest, 0, g_rdy, g_preg);
      chk($sformatf("tbl%0d_rdy", i), g_rdy, tbl[i].e_rdy);
      if (tbl[i].chkp) chk($sformatf("tbl%0d_preg", i), g_preg, tbl[i].e_preg);
      chk($sformatf("tbl%0d_cnt", i), free_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].e_ovf);
    end

    // Overflow from a full list, then a preg-0 free is ignored
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g_rdy, g_preg);
    cycle(0, 0, 2'b11, 7, 9, 0, 0, 0, g_rdy, g_preg);
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", free_cnt, 384);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g_rdy, g_preg);
    cycle(0, 0, 2'b01, 0, 0, 0, 0, 0, g_rdy, g_preg);
    chk("zero_free_ovf", ovf, 0);
    chk("zero_free_cnt", free_cnt, 384);

    // Drain, stall on empty, no-bypass free, then refill grant
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g_rdy, g_preg);
    for (int i = 0; i < CAP; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g_rdy, g_preg);
      if (i == 0 || i == CAP - 1) chk("drain_preg", g_preg, 128 + i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_cnt", free_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g_rdy, g_preg);
      if (i == 0) chk("empty_rdy", g_rdy, 0);
    end
`ifdef QUPLS4_FREELIST_STATS_EN
    chk("stall_10", stall_cnt, 10);
`else
    chk("stall_off", stall_cnt, 0);
`endif
    cycle(1, 0, 2'b01, 200, 0, 0, 0, 0, g_rdy, g_preg);
    chk("nobypass_rdy", g_rdy, 0);
    chk("refill_cnt", free_cnt, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, g_rdy, g_preg);
    chk("refill_rdy", g_rdy, 1);
    chk("refill_preg", g_preg, 200);

    // Checkpoint save at entry 5, 4 grants, restore with a request
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g_rdy, g_preg);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, g_rdy, g_preg);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, g_rdy, g_preg);
    cnt_after_save = 379;
    chk("save_cnt", free_cnt, cnt_after_save);
    first_post_save = 133;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g_rdy, g_preg);
      chk("post_save_preg", g_preg, first_post_save + i);
    end
    cycle(1, 0, 0, 0, 0, 0, 1, 0, g_rdy, g_preg);
    chk("restore_rdy", g_rdy, 0);
    chk("restore_cnt", free_cnt, cnt_after_save);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, g_rdy, g_preg);
    chk("restore_regrant", g_preg, first_post_save);

    // Randomized traffic against the model
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g_rdy, g_preg);
    for (int n = 0; n < 3000; n++) begin
      req  = ($urandom % 10) < 7;
      rdz  = ($urandom % 8) == 0;
      fv   = {($urandom % 100) < 35, ($urandom % 100) < 35};
      p0   = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, NPREG - 1));
      p1   = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, NPREG - 1));
      save = ($urandom % 12) == 0;
      rest = (($urandom % 20) == 0) && (m_tail - m_ckpt <= CAP);
      rst  = ($urandom % 500) == 0;
      cycle(req, rdz, fv, p0, p1, save, rest, rst, g_rdy, g_preg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
